dither_decoder: RTL and testbench

//  Receive-side counterpart of the RGB444 ordered-dither encoder. Takes a 12-bit dithered pixel

---
 rtl/dither_decoder.sv | 248 ++++++++++++++++++++++++
 tb/tb_dither_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dither_decoder.sv
// dither_decoder
// Receive-side counterpart of the RGB444 ordered-dither encoder. Each channel
// is averaged over the 4-pixel horizontal dither period and expanded from
// 4 to 8 bits, turning the 12-bit dithered stream back into RGB888.
//
// Optional feature (macro VERT_AVG_EN):
//   defined   - a one-line buffer of per-column channel sums adds vertical
//               averaging against the previous line; latency is 3 cycles.
//   undefined - horizontal-only reconstruction; latency is 2 cycles.
//
// Stream contract: valid-only, no backpressure. Reset is synchronous and
// active-high, and it wins over any input presented in the same cycle.

module dither_decoder #(
  parameter int H_VISIBLE = 1024,
  parameter int COL_W     = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [11:0]       in_pixel,
  input  logic              in_sol,
  input  logic              in_sof,
  output logic              out_valid,
  output logic [23:0]       out_pixel,
  output logic              out_sol,
  output logic              out_sof,
  output logic              col_err
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_VISIBLE - 1);

  // Adds the four 4-bit history taps of one channel (maximum 60).
  function automatic logic [5:0] sum4(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [3:0] d);
    return 6'(a) + 6'(b) + 6'(c) + 6'(d);
  endfunction

  // Average of four 4-bit samples rescaled to 8 bits: (sum*17 + 2) >> 2.
  function automatic logic [7:0] expand_h(input logic [5:0] s);
    logic [9:0] t;
    t = 10'(s) * 10'd17 + 10'd2;
    return 8'(t >> 2);
  endfunction

  // A start of frame is always also a start of line, even if in_sol is low.
  logic sample_sol;
  assign sample_sol = in_sol | in_sof;

  // Per-channel dither history; h0 holds the newest sample.
  logic [3:0] r_h0, r_h1, r_h2, r_h3;
  logic [3:0] g_h0, g_h1, g_h2, g_h3;
  logic [3:0] b_h0, b_h1, b_h2, b_h3;

  // Column of the most recently accepted sample.
  logic [COL_W-1:0] col_cnt;

  // Stage-1 qualifiers travelling alongside the history registers.
  logic s1_valid, s1_sol, s1_sof;

  // Channel sums of the current history window.
  logic [5:0] sum_r, sum_g, sum_b;

  // History shift: a line start fills all four taps with the first pixel so
  // the previous line's tail never bleeds into the new line; gaps hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h0 <= '0; r_h1 <= '0; r_h2 <= '0; r_h3 <= '0;
      g_h0 <= '0; g_h1 <= '0; g_h2 <= '0; g_h3 <= '0;
      b_h0 <= '0; b_h1 <= '0; b_h2 <= '0; b_h3 <= '0;
    end else if (in_valid) begin
      if (sample_sol) begin
        r_h0 <= in_pixel[11:8]; r_h1 <= in_pixel[11:8];
        r_h2 <= in_pixel[11:8]; r_h3 <= in_pixel[11:8];
        g_h0 <= in_pixel[7:4];  g_h1 <= in_pixel[7:4];
        g_h2 <= in_pixel[7:4];  g_h3 <= in_pixel[7:4];
        b_h0 <= in_pixel[3:0];  b_h1 <= in_pixel[3:0];
        b_h2 <= in_pixel[3:0];  b_h3 <= in_pixel[3:0];
      end else begin
        r_h3 <= r_h2; r_h2 <= r_h1; r_h1 <= r_h0; r_h0 <= in_pixel[11:8];
        g_h3 <= g_h2; g_h2 <= g_h1; g_h1 <= g_h0; g_h0 <= in_pixel[7:4];
        b_h3 <= b_h2; b_h2 <= b_h1; b_h1 <= b_h0; b_h0 <= in_pixel[3:0];
      end
    end
  end

  // Column tracking with saturation; an overlong line latches col_err until
  // the next frame start, and a frame start takes priority over a new error.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      col_err <= 1'b0;
    end else if (in_valid) begin
      if (sample_sol) begin
        col_cnt <= '0;
      end else if (col_cnt != COL_LAST) begin
        col_cnt <= col_cnt + 1'b1;
      end
      if (in_sof) begin
        col_err <= 1'b0;
      end else if (!sample_sol && (col_cnt == COL_LAST)) begin
        col_err <= 1'b1;
      end
    end
  end

  // Stage-1 qualifiers; line/frame flags only count on accepted samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sol   <= 1'b0;
      s1_sof   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_sol   <= in_valid & sample_sol;
      s1_sof   <= in_valid & in_sof;
    end
  end

  // Horizontal sums over the four-pixel dither period.
  always_comb begin
    sum_r = sum4(r_h0, r_h1, r_h2, r_h3);
    sum_g = sum4(g_h0, g_h1, g_h2, g_h3);
    sum_b = sum4(b_h0, b_h1, b_h2, b_h3);
  end

`ifdef VERT_AVG_EN

  localparam int AW = $clog2(H_VISIBLE);

  // Two-line average of 6-bit sums rescaled to 8 bits: ((a+b)*17 + 4) >> 3.
  function automatic logic [7:0] expand_v(input logic [5:0] a, input logic [5:0] b);
    logic [11:0] t;
    t = (12'(a) + 12'(b)) * 12'd17 + 12'd4;
    return 8'(t >> 3);
  endfunction

  // Previous-line sums, one 18-bit {R,G,B} word per visible column.
  logic [17:0] line_mem [H_VISIBLE];
  logic [17:0] sum_cat;
  logic [17:0] prev_rd;
  logic [17:0] sum_cur_q;
  logic [17:0] sum_prev;
  logic [AW-1:0] mem_addr;

  // True while the stage-1 sample belongs to the first line of a frame, and
  // true when the stage-1 sample sits past the last visible column.
  logic first_line;
  logic line_over;

  logic s2_valid, s2_sol, s2_sof, s2_use_cur;

  assign sum_cat  = {sum_r, sum_g, sum_b};
  assign mem_addr = col_cnt[AW-1:0];

  // Line-position flags aligned with the history; after reset the buffer is
  // treated as stale so no pre-reset line is ever averaged in.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_line <= 1'b1;
      line_over  <= 1'b0;
    end else if (in_valid) begin
      if (in_sof) begin
        first_line <= 1'b1;
      end else if (sample_sol) begin
        first_line <= 1'b0;
      end
      line_over <= !sample_sol && (col_cnt == COL_LAST);
    end
  end

  // Line buffer: read the previous line's sum and overwrite it with the
  // current one at the same column; overflow columns are never written.
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      prev_rd <= line_mem[mem_addr];
      if (!line_over) begin
        line_mem[mem_addr] <= sum_cat;
      end
    end
  end

  // Stage 2 registers the current sums and decides whether the previous
  // line is usable or the current sums must stand in for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_sol     <= 1'b0;
      s2_sof     <= 1'b0;
      s2_use_cur <= 1'b0;
      sum_cur_q  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sol   <= s1_sol;
      s2_sof   <= s1_sof;
      if (s1_valid) begin
        sum_cur_q  <= sum_cat;
        s2_use_cur <= first_line | line_over;
      end
    end
  end

  // Previous-line sums with the first-line / overflow fallback applied.
  always_comb begin
    sum_prev = s2_use_cur ? sum_cur_q : prev_rd;
  end

  // Stage 3 output register; the pixel holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_sof   <= 1'b0;
      out_pixel <= '0;
    end else begin
      out_valid <= s2_valid;
      out_sol   <= s2_sol;
      out_sof   <= s2_sof;
      if (s2_valid) begin
        out_pixel <= {expand_v(sum_cur_q[17:12], sum_prev[17:12]),
                      expand_v(sum_cur_q[11:6],  sum_prev[11:6]),
                      expand_v(sum_cur_q[5:0],   sum_prev[5:0])};
      end
    end
  end

`else

  // Stage 2 output register; the pixel holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_sof   <= 1'b0;
      out_pixel <= '0;
    end else begin
      out_valid <= s1_valid;
      out_sol   <= s1_sol;
      out_sof   <= s1_sof;
      if (s1_valid) begin
        out_pixel <= {expand_h(sum_r), expand_h(sum_g), expand_h(sum_b)};
      end
    end
  end

`endif

endmodule

// File: tb/tb_dither_decoder.sv
// tb_dither_decoder
// Directed bench for dither_decoder in its default horizontal-only build.
// Inputs change on the falling edge; outputs are compared on the falling
// edge two samples after the stimulus that produced them.

module tb_dither_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_pixel;
  logic        in_sol;
  logic        in_sof;
  logic        out_valid;
  logic [23:0] out_pixel;
  logic        out_sol;
  logic        out_sof;
  logic        col_err;

  int n_checks;
  int n_pass;
  int n_fail;

  // Expected outputs for the two samples still in flight; index 1 is oldest.
  logic        exp_v [2];
  logic        exp_s [2];
  logic        exp_f [2];
  logic [23:0] exp_p [2];
  string       exp_t [2];
  int          hist_cnt;

  dither_decoder #(
    .H_VISIBLE(1024),
    .COL_W(11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_pixel(in_pixel),
    .in_sol(in_sol),
    .in_sof(in_sof),
    .out_valid(out_valid),
    .out_pixel(out_pixel),
    .out_sol(out_sol),
    .out_sof(out_sof),
    .col_err(col_err)
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  // One comparison: counts it and reports tag, observed and expected on a miss.
  task automatic checkVal(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares all qualified outputs against one expected sample.
  task automatic checkOutput(input string tag, input logic ev, input logic [23:0] ep,
                             input logic es, input logic ef);
    checkVal({tag, ".out_valid"}, 24'(out_valid), 24'(ev));
    checkVal({tag, ".out_pixel"}, out_pixel, ep);
    checkVal({tag, ".out_sol"}, 24'(out_sol), 24'(es));
    checkVal({tag, ".out_sof"}, 24'(out_sof), 24'(ef));
  endtask

  // Drives one cycle of input and first checks the sample driven two calls ago.
  task automatic applyStimulus(input logic v, input logic [11:0] pix, input logic sol,
                               input logic sof, input logic [23:0] exp_pix, input string tag);
    @(negedge clk);
    if (hist_cnt >= 2) checkOutput(exp_t[1], exp_v[1], exp_p[1], exp_s[1], exp_f[1]);
    in_valid = v;
    in_pixel = pix;
    in_sol   = sol;
    in_sof   = sof;
    exp_v[1] = exp_v[0]; exp_p[1] = exp_p[0];
    exp_s[1] = exp_s[0]; exp_f[1] = exp_f[0]; exp_t[1] = exp_t[0];
    exp_v[0] = v;
    exp_p[0] = exp_pix;
    exp_s[0] = v & sol;
    exp_f[0] = v & sof;
    exp_t[0] = tag;
    if (hist_cnt < 2) hist_cnt++;
  endtask

  // Directed sequence.
  initial begin
    logic [23:0] t4_exp [6];
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    hist_cnt = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    in_sol   = 1'b0;
    in_sof   = 1'b0;

    $display("[TB] reset with toggling input");
    @(negedge clk); in_valid = 1'b1; in_pixel = 12'hFFF; in_sol = 1'b1; in_sof = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_sol = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    checkVal("rst.out_valid", 24'(out_valid), 24'h0);
    checkVal("rst.out_pixel", out_pixel, 24'h000000);
    checkVal("rst.col_err", 24'(col_err), 24'h0);
    checkVal("rst.out_sof", 24'(out_sof), 24'h0);
    in_valid = 1'b0;
    rst = 1'b0;

    $display("[TB] white frame start");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 12'hFFF, i == 0, i == 0, 24'hFFFFFF, "t2.white");
    end

    $display("[TB] new line does not bleed");
    applyStimulus(1'b1, 12'h000, 1'b1, 1'b0, 24'h000000, "t3.sol_black");
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'h000000, "t3.gap");
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'h000000, "t3.gap");

    $display("[TB] red dither pattern");
    t4_exp[0] = 24'h440000;
    t4_exp[1] = 24'h480000;
    t4_exp[2] = 24'h480000;
    t4_exp[3] = 24'h4D0000;
    t4_exp[4] = 24'h4D0000;
    t4_exp[5] = 24'h4D0000;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? 12'h400 : 12'h500, i == 0, 1'b0, t4_exp[i], "t4.red");
    end

    $display("[TB] bubbles hold history");
    applyStimulus(1'b1, 12'h100, 1'b1, 1'b0, 24'h110000, "t5.sol");
    applyStimulus(1'b0, 12'h700, 1'b0, 1'b0, 24'h110000, "t5.gap");
    applyStimulus(1'b0, 12'h700, 1'b0, 1'b0, 24'h110000, "t5.gap");
    applyStimulus(1'b1, 12'h300, 1'b0, 1'b0, 24'h1A0000, "t5.after_gap1");
    applyStimulus(1'b1, 12'h300, 1'b0, 1'b0, 24'h220000, "t5.after_gap2");
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'h220000, "t5.flush");
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'h220000, "t5.flush");

    $display("[TB] reset mid-line clears history");
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_sol = 1'b0; in_sof = 1'b0;
    hist_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    checkVal("t7.rst_pixel", out_pixel, 24'h000000);
    applyStimulus(1'b1, 12'h100, 1'b0, 1'b0, 24'h040000, "t7.first");
    applyStimulus(1'b1, 12'h100, 1'b0, 1'b0, 24'h090000, "t7.second");
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'h090000, "t7.flush");
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'h090000, "t7.flush");

    $display("[TB] overlong line");
    for (int i = 0; i <= 1024; i++) begin
      applyStimulus(1'b1, 12'hFFF, i == 0, 1'b0, 24'hFFFFFF, "t6.line");
      if (i == 1024) checkVal("t6.col_err_at_limit", 24'(col_err), 24'h0);
    end
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'hFFFFFF, "t6.gap");
    checkVal("t6.col_err_set", 24'(col_err), 24'h1);
    applyStimulus(1'b1, 12'h000, 1'b1, 1'b0, 24'h000000, "t6.sol_only");
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'h000000, "t6.gap");
    checkVal("t6.col_err_sticky", 24'(col_err), 24'h1);
    applyStimulus(1'b1, 12'h000, 1'b1, 1'b1, 24'h000000, "t6.sof");
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'h000000, "t6.gap");
    checkVal("t6.col_err_cleared", 24'(col_err), 24'h0);
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 24'h000000, "t6.flush");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
